// File: rtl/if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl
//   Instruction-fetch controller for the IF stage. Takes the current PC,
//   issues one request on the SRAM-like instruction bus and holds the returned
//   word for ID. It stalls the PC register while a fetch is in flight and
//   discards responses of fetches killed by a redirect (flush).
//
//   Handshake semantics: a bus request transfers on the cycle where
//   o_inst_req=1 and i_inst_addr_ok=1. Read data transfers on the cycle where
//   i_inst_data_ok=1, which comes at least one cycle after that. The held
//   instruction transfers to ID on the cycle where o_id_valid=1 and
//   i_id_ready=1. Only one bus transaction is ever outstanding.
//
//   Optional feature (macro FETCH_ADEL_CHECK_EN): a misaligned PC raises an
//   address-error instruction (NOP + o_id_adel) without touching the bus.
//   When the macro is undefined, o_id_adel is always 0 and misaligned
//   addresses go out on the bus unchanged.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_pc_addr         current PC from the PC register
//   i_flush           redirect this cycle; kills the current fetch
//   i_id_ready        ID accepts the held instruction
//   o_inst_req        bus request valid
//   o_inst_addr       bus request address
//   i_inst_addr_ok    bus accepted the address
//   i_inst_data_ok    read data valid
//   i_inst_rdata      read data
//   o_fetch_stall     stall to the PC register (combinational)
//   o_id_valid        o_id_pc / o_id_inst valid
//   o_id_pc           PC of the held instruction
//   o_id_inst         held instruction word
//   o_id_adel         fetch address error flag of the held instruction
//   o_dbg_state       current FSM state (0 IDLE,1 REQ,2 WAIT,3 HOLD,4 DROP)
// ----------------------------------------------------------------------------
module if_fetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_pc_addr,
    input  logic              i_flush,
    input  logic              i_id_ready,
    output logic              o_inst_req,
    output logic [ADDR_W-1:0] o_inst_addr,
    input  logic              i_inst_addr_ok,
    input  logic              i_inst_data_ok,
    input  logic [DATA_W-1:0] i_inst_rdata,
    output logic              o_fetch_stall,
    output logic              o_id_valid,
    output logic [ADDR_W-1:0] o_id_pc,
    output logic [DATA_W-1:0] o_id_inst,
    output logic              o_id_adel,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_inst_req;
    logic [ADDR_W-1:0] r_inst_addr;
    logic              r_id_valid;
    logic [ADDR_W-1:0] r_id_pc;
    logic [DATA_W-1:0] r_id_inst;
    logic              r_id_adel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= '0;
            r_inst_req  <= 1'b0;
            r_inst_addr <= '0;
            r_id_valid  <= 1'b0;
            r_id_pc     <= '0;
            r_id_inst   <= '0;
            r_id_adel   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!i_flush) begin
`ifdef FETCH_ADEL_CHECK_EN
                        if (i_pc_addr[1:0] != 2'b00) begin
                            // Address error: hand ID a NOP flagged as ADEL.
                            r_state    <= S_HOLD;
                            r_id_valid <= 1'b1;
                            r_id_pc    <= i_pc_addr;
                            r_id_inst  <= '0;
                            r_id_adel  <= 1'b1;
                        end else
`endif
                        begin
                            r_fetch_pc  <= i_pc_addr;
                            r_inst_req  <= 1'b1;
                            r_inst_addr <= i_pc_addr;
                            r_state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (i_inst_addr_ok) begin
                        r_inst_req <= 1'b0;
                        // Accepted but killed: the response is still owed.
                        r_state    <= i_flush ? S_DROP : S_WAIT;
                    end else if (i_flush) begin
                        // Withdraw the request before the bus took it.
                        r_inst_req <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (i_inst_data_ok) begin
                        if (i_flush) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state    <= S_HOLD;
                            r_id_valid <= 1'b1;
                            r_id_pc    <= r_fetch_pc;
                            r_id_inst  <= i_inst_rdata;
                            r_id_adel  <= 1'b0;
                        end
                    end else if (i_flush) begin
                        r_state <= S_DROP;
                    end
                end
                S_HOLD: begin
                    if (i_flush || i_id_ready) begin
                        r_state    <= S_IDLE;
                        r_id_valid <= 1'b0;
                        r_id_adel  <= 1'b0;
                    end
                end
                S_DROP: begin
                    if (i_inst_data_ok) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // PC advances exactly on the ID handoff, and always on a redirect.
    assign o_fetch_stall = !(i_flush || ((r_state == S_HOLD) && i_id_ready));

    assign o_inst_req  = r_inst_req;
    assign o_inst_addr = r_inst_addr;
    assign o_id_valid  = r_id_valid;
    assign o_id_pc     = r_id_pc;
    assign o_id_inst   = r_id_inst;
`ifdef FETCH_ADEL_CHECK_EN
    assign o_id_adel   = r_id_adel;
`else
    assign o_id_adel   = 1'b0;
`endif
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_ctrl
//   Bench for if_fetch_ctrl. A transaction-level model (request pending,
//   response owed/killed, instruction held) predicts every output each cycle.
//   A bus responder obeys the addr_ok/data_ok rules with random delays.
//   Directed sequences with literal expectations come first, then random
//   traffic with occasional resets, flushes and misaligned PCs.
// ----------------------------------------------------------------------------
module tb_if_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc_addr;
    logic        flush;
    logic        id_ready;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fetch_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;
    logic [2:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    if_fetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pc_addr      (pc_addr),
        .i_flush        (flush),
        .i_id_ready     (id_ready),
        .o_inst_req     (inst_req),
        .o_inst_addr    (inst_addr),
        .i_inst_addr_ok (inst_addr_ok),
        .i_inst_data_ok (inst_data_ok),
        .i_inst_rdata   (inst_rdata),
        .o_fetch_stall  (fetch_stall),
        .o_id_valid     (id_valid),
        .o_id_pc        (id_pc),
        .o_id_inst      (id_inst),
        .o_id_adel      (id_adel),
        .o_dbg_state    (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FETCH_ADEL_CHECK_EN
    localparam bit ADEL_EN = 1'b1;
`else
    localparam bit ADEL_EN = 1'b0;
`endif

    // ---------------- model state ----------------
    bit          m_req_pending;   // request on bus, not yet accepted
    bit          m_resp_owed;     // accepted, data not yet returned
    bit          m_killed;        // owed response belongs to a killed fetch
    bit          m_hold;          // instruction waiting for ID
    logic [31:0] m_addr, m_fpc, m_pc, m_inst;
    bit          m_adel;

    // bus responder state
    bit          mem_owed;
    int          mem_delay;

    logic        last_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit t_rst, t_flush, t_ready, input logic [31:0] t_pc,
                              input bit t_aok, t_dok, input logic [31:0] t_rdata);
        if (t_rst) begin
            m_req_pending = 0; m_resp_owed = 0; m_killed = 0; m_hold = 0;
            m_addr = 0; m_fpc = 0; m_pc = 0; m_inst = 0; m_adel = 0;
        end else if (m_req_pending) begin
            if (t_aok) begin
                m_req_pending = 0;
                m_resp_owed   = 1;
                m_killed      = t_flush;
            end else if (t_flush) begin
                m_req_pending = 0;
            end
        end else if (m_resp_owed) begin
            if (t_dok) begin
                m_resp_owed = 0;
                if (!m_killed && !t_flush) begin
                    m_hold = 1; m_pc = m_fpc; m_inst = t_rdata; m_adel = 0;
                end
            end else if (t_flush) begin
                m_killed = 1;
            end
        end else if (m_hold) begin
            if (t_flush || t_ready) begin
                m_hold = 0; m_adel = 0;
            end
        end else if (!t_flush) begin
            if (ADEL_EN && t_pc[1:0] != 2'b00) begin
                m_hold = 1; m_pc = t_pc; m_inst = 0; m_adel = 1;
            end else begin
                m_req_pending = 1; m_addr = t_pc; m_fpc = t_pc;
            end
        end
    endtask

    // One clock cycle: drive at negedge, check stall, update models at
    // posedge, then compare the registered outputs.
    task automatic cycle(input bit t_rst, t_flush, t_ready, input logic [31:0] t_pc,
                         input bit t_aok, t_dok, input logic [31:0] t_rdata);
        bit req_seen;
        @(negedge clk);
        rst = t_rst; flush = t_flush; id_ready = t_ready; pc_addr = t_pc;
        inst_addr_ok = t_aok; inst_data_ok = t_dok; inst_rdata = t_rdata;
        req_seen = inst_req;
        #1;
        last_stall = fetch_stall;
        if (!t_rst)
            chk("fetch_stall", {31'b0, fetch_stall}, {31'b0, !(t_flush || (m_hold && t_ready))});
        @(posedge clk);
        model_step(t_rst, t_flush, t_ready, t_pc, t_aok, t_dok, t_rdata);
        if (t_rst) begin
            mem_owed = 0;
        end else begin
            if (t_dok) mem_owed = 0;
            if (req_seen && t_aok) begin
                mem_owed  = 1;
                mem_delay = $urandom_range(0, 3);
            end else if (mem_owed && mem_delay > 0) begin
                mem_delay--;
            end
        end
        #1;
        chk("inst_req",  {31'b0, inst_req}, {31'b0, m_req_pending});
        chk("inst_addr", inst_addr, m_addr);
        chk("id_valid",  {31'b0, id_valid}, {31'b0, m_hold});
        chk("id_pc",     id_pc, m_pc);
        chk("id_inst",   id_inst, m_inst);
        chk("id_adel",   {31'b0, id_adel}, {31'b0, m_adel});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; flush = 0; id_ready = 0; pc_addr = 0;
        inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
        mem_owed = 0; mem_delay = 0;
        model_step(1, 0, 0, 0, 0, 0, 0);

        repeat (3) cycle(1, 0, 0, 32'h1234_5678, 0, 0, 0);
        chk("rst_inst_req", {31'b0, inst_req}, 32'd0);
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_inst_addr", inst_addr, 32'd0);

        // Boot fetch with zero-wait memory.
        cycle(0, 0, 1, 32'hbfc0_0000, 0, 0, 0);
        chk("t1_stall_idle", {31'b0, last_stall}, 32'd1);
        chk("t1_req", {31'b0, inst_req}, 32'd1);
        chk("t1_addr", inst_addr, 32'hbfc0_0000);
        cycle(0, 0, 1, 32'hbfc0_0000, 1, 0, 0);
        chk("t1_req_drop", {31'b0, inst_req}, 32'd0);
        cycle(0, 0, 1, 32'hbfc0_0000, 0, 1, 32'h3c08_bfc0);
        chk("t1_valid", {31'b0, id_valid}, 32'd1);
        chk("t1_inst", id_inst, 32'h3c08_bfc0);
        chk("t1_pc", id_pc, 32'hbfc0_0000);
        cycle(0, 0, 1, 32'hbfc0_0004, 0, 0, 0);
        chk("t1_stall_hold", {31'b0, last_stall}, 32'd0);
        chk("t1_valid_clr", {31'b0, id_valid}, 32'd0);

        // Flush in WAIT, orphan response 0xdeadbeef, then redirected fetch.
        cycle(0, 0, 0, 32'hbfc0_0100, 0, 0, 0);
        cycle(0, 0, 0, 32'hbfc0_0100, 1, 0, 0);
        cycle(0, 1, 0, 32'hbfc0_0380, 0, 0, 0);
        chk("t4_stall_flush", {31'b0, last_stall}, 32'd0);
        cycle(0, 0, 0, 32'hbfc0_0380, 0, 0, 0);
        cycle(0, 0, 0, 32'hbfc0_0380, 0, 1, 32'hdead_beef);
        chk("t4_valid", {31'b0, id_valid}, 32'd0);
        chk("t4_no_dead", {31'b0, id_inst == 32'hdead_beef}, 32'd0);
        cycle(0, 0, 0, 32'hbfc0_0380, 0, 0, 0);
        chk("t4_redirect_addr", inst_addr, 32'hbfc0_0380);
        cycle(0, 0, 0, 32'hbfc0_0380, 1, 0, 0);
        cycle(0, 0, 0, 32'hbfc0_0380, 0, 1, 32'h0000_0021);
        chk("t4_pc", id_pc, 32'hbfc0_0380);
        cycle(0, 0, 1, 32'hbfc0_0384, 0, 0, 0);

        // Misaligned PC.
        cycle(0, 0, 0, 32'hbfc0_0002, 0, 0, 0);
`ifdef FETCH_ADEL_CHECK_EN
        chk("t6_req", {31'b0, inst_req}, 32'd0);
        chk("t6_valid", {31'b0, id_valid}, 32'd1);
        chk("t6_adel", {31'b0, id_adel}, 32'd1);
        chk("t6_inst", id_inst, 32'd0);
        cycle(0, 0, 1, 32'hbfc0_0180, 0, 0, 0);
`else
        chk("t6_req", {31'b0, inst_req}, 32'd1);
        chk("t6_addr", inst_addr, 32'hbfc0_0002);
        cycle(0, 0, 0, 32'hbfc0_0002, 1, 0, 0);
        cycle(0, 0, 0, 32'hbfc0_0002, 0, 1, 32'h1111_2222);
        chk("t6_adel", {31'b0, id_adel}, 32'd0);
        cycle(0, 0, 1, 32'hbfc0_0006, 0, 0, 0);
`endif

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            bit          r_rst, r_fl, r_rdy, r_aok, r_dok;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 399) == 0);
            r_fl  = ($urandom_range(0, 9) == 0);
            r_rdy = $urandom_range(0, 1);
            r_pc  = $urandom;
            if ($urandom_range(0, 7) != 0) r_pc[1:0] = 2'b00;
            r_aok = !r_rst && inst_req && !mem_owed && ($urandom_range(0, 1) == 1);
            r_dok = !r_rst && mem_owed && (mem_delay == 0);
            cycle(r_rst, r_fl, r_rdy, r_pc, r_aok, r_dok, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
